// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank driver: FSM states and per-bit J/K codes.
package jk_pkg;

    // Driver sequence: accept, pulse, wait for the bank to settle, verify.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    // {j, k} excitation codes for a single JK flop.
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excite.sv
// Per-bit J/K excitation: the code that moves one JK flop from cur to tgt.
module jk_excite
    import jk_pkg::*;
(
    input  logic cur,
    input  logic tgt,
    input  logic prefer_toggle,
    output logic j,
    output logic k
);

    logic [1:0] code;

    // Pick HOLD for unchanged bits, otherwise SET/RESET or TOGGLE.
    always_comb begin
        // NOTE: the default assignment first covers every path, so no latch is inferred.
        code = JK_HOLD;
        if (cur != tgt) begin
            if (prefer_toggle) begin
                code = JK_TOGGLE;
            end else if (tgt) begin
                code = JK_SET;
            end else begin
                code = JK_RESET;
            end
        end
    end

    assign {j, k} = code;

endmodule

// File: rtl/jk_bank_driver.sv
// Drives an external bank of JK flops to a requested value: computes J/K from
// the current bank state, pulses it for one cycle, waits, and verifies.
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYC    = 1,
    parameter int PREFER_TOGGLE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_bits
);

    // Last SETTLE count value; unused when the settle phase is skipped.
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);
    localparam logic       TOGGLE_EN   = (PREFER_TOGGLE != 0);
    localparam state_t     AFTER_DRIVE = (SETTLE_CYC == 0) ? CHECK : SETTLE;

    state_t           state;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] tgt_r;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;
    logic [WIDTH-1:0] diff;

    // One excitation cell per bank bit, fed from live feedback and the incoming word.
    for (genvar i = 0; i < WIDTH; i++) begin : g_excite
        jk_excite u_excite (
            .cur           (q_fb[i]),
            .tgt           (tgt_data[i]),
            .prefer_toggle (TOGGLE_EN),
            .j             (exc_j[i]),
            .k             (exc_k[i])
        );
    end

    assign tgt_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign diff      = q_fb ^ tgt_r;

    // Sequencer: j/k and done/err default low so each is a single-cycle pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            tgt_r      <= '0;
            j          <= '0;
            k          <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_bits   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            j    <= '0;
            k    <= '0;
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        tgt_r <= tgt_data;
                        j     <= exc_j;
                        k     <= exc_k;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    settle_cnt <= '0;
                    state      <= AFTER_DRIVE;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    done     <= 1'b1;
                    err      <= |diff;
                    err_bits <= diff;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Self-checking bench: two drivers (set/reset with one settle cycle, and
// toggle with no settle) each loop back through a behavioural JK bank.
module tb_jk_bank_driver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         tgt_valid = 1'b0;
    logic [W-1:0] tgt_data = '0;
    logic [W-1:0] fault_mask = '0;

    logic [W-1:0] bank_a, bank_b, q_fb_a, q_fb_b;
    logic [W-1:0] j_a, k_a, j_b, k_b, err_bits_a, err_bits_b;
    logic         tgt_ready_a, tgt_ready_b, busy_a, busy_b;
    logic         done_a, done_b, err_a, err_b;

    // Reference state: what the bank should hold after each transaction.
    logic [W-1:0] m_bank_a, m_bank_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jk_bank_driver #(.WIDTH(W), .SETTLE_CYC(1), .PREFER_TOGGLE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready_a),
        .tgt_data(tgt_data), .q_fb(q_fb_a), .j(j_a), .k(k_a), .busy(busy_a),
        .done(done_a), .err(err_a), .err_bits(err_bits_a)
    );

    jk_bank_driver #(.WIDTH(W), .SETTLE_CYC(0), .PREFER_TOGGLE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready_b),
        .tgt_data(tgt_data), .q_fb(q_fb_b), .j(j_b), .k(k_b), .busy(busy_b),
        .done(done_b), .err(err_b), .err_bits(err_bits_b)
    );

    // JK flop banks: Q+ = J&~Q | ~K&Q, cleared by the shared reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_a <= '0;
            bank_b <= '0;
        end else begin
            bank_a <= (j_a & ~bank_a) | (~k_a & bank_a);
            bank_b <= (j_b & ~bank_b) | (~k_b & bank_b);
        end
    end

    assign q_fb_a = bank_a & ~fault_mask;
    assign q_fb_b = bank_b;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Bits that must rise get J, bits that must fall get K; toggle mode uses both.
    function automatic void model_excite(input logic [W-1:0] cur, input logic [W-1:0] tgt,
                                         input bit tog, output logic [W-1:0] ej,
                                         output logic [W-1:0] ek);
        logic [W-1:0] rise, fall;
        rise = tgt & ~cur;
        fall = cur & ~tgt;
        ej = tog ? (rise | fall) : rise;
        ek = tog ? (rise | fall) : fall;
    endfunction

    // One transaction on both drivers; A finishes in cycle 4, B in cycle 3.
    task automatic run_txn(input logic [W-1:0] d);
        logic [W-1:0] ej_a, ek_a, ej_b, ek_b, seen_a, exp_eb;
        int da, db;
        seen_a = m_bank_a & ~fault_mask;
        model_excite(seen_a, d, 1'b0, ej_a, ek_a);
        model_excite(m_bank_b, d, 1'b1, ej_b, ek_b);
        exp_eb = (d & ~fault_mask) ^ d;
        @(negedge clk);
        check("ready_a", 32'(tgt_ready_a), 32'd1);
        check("ready_b", 32'(tgt_ready_b), 32'd1);
        tgt_valid = 1'b1;
        tgt_data  = d;
        @(posedge clk);
        #1 tgt_valid = 1'b0;
        da = 0;
        db = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("drive_j_a", 32'(j_a), 32'(ej_a));
                check("drive_k_a", 32'(k_a), 32'(ek_a));
                check("drive_j_b", 32'(j_b), 32'(ej_b));
                check("drive_k_b", 32'(k_b), 32'(ek_b));
                check("busy_a", 32'(busy_a), 32'd1);
                check("busy_b", 32'(busy_b), 32'd1);
                check("ready_busy_a", 32'(tgt_ready_a), 32'd0);
            end else begin
                check("quiet_jk_a", 32'(j_a | k_a), 32'd0);
                check("quiet_jk_b", 32'(j_b | k_b), 32'd0);
            end
            if (done_a) begin
                da++;
                check("done_cyc_a", 32'(c), 32'd4);
                check("err_a", 32'(err_a), 32'(exp_eb != '0));
                check("err_bits_a", 32'(err_bits_a), 32'(exp_eb));
            end
            if (done_b) begin
                db++;
                check("done_cyc_b", 32'(c), 32'd3);
                check("err_b", 32'(err_b), 32'd0);
                check("err_bits_b", 32'(err_bits_b), 32'd0);
            end
        end
        check("done_cnt_a", 32'(da), 32'd1);
        check("done_cnt_b", 32'(db), 32'd1);
        check("q_fb_a", 32'(q_fb_a), 32'(d & ~fault_mask));
        check("q_fb_b", 32'(q_fb_b), 32'(d));
        check("hold_bits_a", 32'(err_bits_a), 32'(exp_eb));
        m_bank_a = d;
        m_bank_b = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int da, db, a1, a2, b1, b2;
        m_bank_a = '0;
        m_bank_b = '0;

        // Reset state.
        #12;
        check("rst_j", 32'(j_a | j_b), 32'd0);
        check("rst_k", 32'(k_a | k_b), 32'd0);
        check("rst_busy", 32'({busy_a, busy_b}), 32'd0);
        check("rst_done", 32'({done_a, done_b, err_a, err_b}), 32'd0);
        check("rst_err_bits", 32'(err_bits_a | err_bits_b), 32'd0);
        check("rst_ready", 32'({tgt_ready_a, tgt_ready_b}), 32'd3);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Baseline and set/reset/toggle excitation, then an unchanged target.
        run_txn(8'hA5);
        run_txn(8'h3C);
        run_txn(8'h3C);

        // Stuck-at-0 on bit 3 of bank A.
        run_txn(8'h00);
        fault_mask = 8'h08;
        run_txn(8'hFF);
        fault_mask = 8'h00;

        // Reset during DRIVE: outputs clear at once, no done afterwards.
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_data  = 8'h12;
        @(posedge clk);
        #1 tgt_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_jk", 32'(j_a | k_a | j_b | k_b), 32'd0);
        check("mid_rst_busy", 32'({busy_a, busy_b}), 32'd0);
        check("mid_rst_done", 32'({done_a, done_b}), 32'd0);
        check("mid_rst_err_bits", 32'(err_bits_a), 32'd0);
        check("mid_rst_ready", 32'({tgt_ready_a, tgt_ready_b}), 32'd3);
        @(negedge clk);
        reset_n = 1'b1;
        da = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done_a || done_b) da++;
        end
        check("no_done_after_rst", 32'(da), 32'd0);
        check("ready_after_rst", 32'({tgt_ready_a, tgt_ready_b}), 32'd3);
        m_bank_a = '0;
        m_bank_b = '0;

        // Back-to-back: valid held, second word taken in each driver's done cycle.
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_data  = 8'h0F;
        @(posedge clk);
        #1 tgt_data = 8'hF0;
        da = 0; db = 0; a1 = 0; a2 = 0; b1 = 0; b2 = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 5) tgt_valid = 1'b0;
            if (done_a) begin
                da++;
                if (da == 1) a1 = c; else a2 = c;
                check("b2b_err_a", 32'(err_a), 32'd0);
                check("b2b_ready_a", 32'(tgt_ready_a), 32'd1);
            end
            if (done_b) begin
                db++;
                if (db == 1) b1 = c; else b2 = c;
                check("b2b_err_b", 32'(err_b), 32'd0);
            end
        end
        check("b2b_cnt_a", 32'(da), 32'd2);
        check("b2b_cnt_b", 32'(db), 32'd2);
        check("b2b_first_a", 32'(a1), 32'd4);
        check("b2b_gap_a", 32'(a2 - a1), 32'd4);
        check("b2b_first_b", 32'(b1), 32'd3);
        check("b2b_gap_b", 32'(b2 - b1), 32'd3);
        check("b2b_q_a", 32'(q_fb_a), 32'h0F0);
        check("b2b_q_b", 32'(q_fb_b), 32'h0F0);
        m_bank_a = 8'hF0;
        m_bank_b = 8'hF0;

        // Randomized targets against the reference model.
        for (int n = 0; n < 24; n++) begin
            run_txn(8'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
